// File: rtl/sp_unit.sv
// rtl/sp_unit.sv - parametrised stack/frame pointer unit with bounds checking
// Stack grows down inside [STACK_LIMIT, STACK_TOP]; rejected ops leave SP untouched and raise sticky faults.
module sp_unit #(
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned STEP_WIDTH  = 3,
  parameter int unsigned STACK_TOP   = (1 << ADDR_WIDTH) - 1,
  parameter int unsigned STACK_LIMIT = (1 << ADDR_WIDTH) - 256
) (
  input  logic                  clk,
  input  logic                  rst_async,
  input  logic [2:0]            sp_op,
  input  logic [STEP_WIDTH-1:0] sp_amount,
  input  logic [ADDR_WIDTH-1:0] sp_load_value,
  input  logic                  fault_clear,
  output logic [ADDR_WIDTH-1:0] sp_addr,
  output logic [ADDR_WIDTH-1:0] fp_addr,
  output logic [ADDR_WIDTH-1:0] sp_depth,
  output logic [ADDR_WIDTH-1:0] sp_watermark,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  op_rejected
);

  if (STACK_LIMIT >= STACK_TOP) begin : g_bad_window
    $error("sp_unit: STACK_LIMIT must be below STACK_TOP");
  end

  localparam logic [2:0] OP_PUSH       = 3'd1;
  localparam logic [2:0] OP_POP        = 3'd2;
  localparam logic [2:0] OP_LOAD       = 3'd3;
  localparam logic [2:0] OP_SET_FP     = 3'd4;
  localparam logic [2:0] OP_RESTORE_SP = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] TOP_A   = ADDR_WIDTH'(STACK_TOP);
  localparam logic [ADDR_WIDTH:0]   TOP_X   = (ADDR_WIDTH+1)'(STACK_TOP);
  localparam logic [ADDR_WIDTH:0]   LIMIT_X = (ADDR_WIDTH+1)'(STACK_LIMIT);

  logic [ADDR_WIDTH:0]   sp_ext, amt_ext, load_ext, push_val, pop_val;
  logic [ADDR_WIDTH-1:0] sp_next, fp_next, wm_next;
  logic                  rej_ovf, rej_unf;

  // One extra bit keeps the compares free of wrap-around; the push test is
  // phrased as sp >= limit + amount so it cannot borrow below zero.
  assign sp_ext   = {1'b0, sp_addr};
  assign amt_ext  = {{(ADDR_WIDTH+1-STEP_WIDTH){1'b0}}, sp_amount};
  assign load_ext = {1'b0, sp_load_value};
  assign push_val = sp_ext - amt_ext;
  assign pop_val  = sp_ext + amt_ext;

  always_comb begin
    sp_next = sp_addr;
    fp_next = fp_addr;
    rej_ovf = 1'b0;
    rej_unf = 1'b0;
    case (sp_op)
      OP_PUSH: begin
        if (sp_ext >= LIMIT_X + amt_ext) sp_next = push_val[ADDR_WIDTH-1:0];
        else                             rej_ovf = 1'b1;
      end
      OP_POP: begin
        if (pop_val <= TOP_X) sp_next = pop_val[ADDR_WIDTH-1:0];
        else                  rej_unf = 1'b1;
      end
      OP_LOAD: begin
        if (load_ext < LIMIT_X)     rej_ovf = 1'b1;
        else if (load_ext > TOP_X)  rej_unf = 1'b1;
        else                        sp_next = sp_load_value;
      end
      OP_SET_FP:     fp_next = sp_addr;
      OP_RESTORE_SP: sp_next = fp_addr;
      default: ;
    endcase
  end

  always_comb begin
    wm_next = sp_watermark;
    if (fault_clear || (sp_next < sp_watermark)) wm_next = sp_next;
  end

  assign sp_depth = TOP_A - sp_addr;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      sp_addr      <= TOP_A;
      fp_addr      <= TOP_A;
      sp_watermark <= TOP_A;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      op_rejected  <= 1'b0;
    end else begin
      sp_addr      <= sp_next;
      fp_addr      <= fp_next;
      sp_watermark <= wm_next;
      // A fault raised alongside fault_clear wins.
      overflow     <= rej_ovf | (overflow & ~fault_clear);
      underflow    <= rej_unf | (underflow & ~fault_clear);
      op_rejected  <= rej_ovf | rej_unf;
    end
  end

endmodule

// File: tb/tb_sp_unit.sv
// tb/tb_sp_unit.sv - directed and randomized checks of sp_unit against an integer reference model
module tb_sp_unit;
  localparam int AW    = 14;
  localparam int SW    = 3;
  localparam int TOP   = 'h3FFF;
  localparam int LIMIT = 'h3F00;

  logic          clk = 1'b0;
  logic          rst_async = 1'b0;
  logic [2:0]    sp_op = 3'd0;
  logic [SW-1:0] sp_amount = '0;
  logic [AW-1:0] sp_load_value = '0;
  logic          fault_clear = 1'b0;
  logic [AW-1:0] sp_addr, fp_addr, sp_depth, sp_watermark;
  logic          overflow, underflow, op_rejected;

  int tests = 0;
  int fails = 0;
  int m_sp, m_fp, m_wm;
  bit m_ovf, m_unf, m_rej;

  sp_unit dut (
    .clk(clk), .rst_async(rst_async), .sp_op(sp_op), .sp_amount(sp_amount),
    .sp_load_value(sp_load_value), .fault_clear(fault_clear),
    .sp_addr(sp_addr), .fp_addr(fp_addr), .sp_depth(sp_depth),
    .sp_watermark(sp_watermark), .overflow(overflow), .underflow(underflow),
    .op_rejected(op_rejected)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_sp = TOP; m_fp = TOP; m_wm = TOP;
    m_ovf = 0; m_unf = 0; m_rej = 0;
  endtask

  // Plain arithmetic on unbounded ints: legal iff the result stays inside the window.
  task automatic model_op(input int op, input int amt, input int val, input bit clr);
    int nsp;
    bit o, u;
    nsp = m_sp; o = 0; u = 0;
    case (op)
      1: if (m_sp - amt >= LIMIT) nsp = m_sp - amt; else o = 1;
      2: if (m_sp + amt <= TOP)   nsp = m_sp + amt; else u = 1;
      3: if (val < LIMIT) o = 1; else if (val > TOP) u = 1; else nsp = val;
      4: m_fp = m_sp;
      5: nsp = m_fp;
      default: ;
    endcase
    m_ovf = o || (m_ovf && !clr);
    m_unf = u || (m_unf && !clr);
    m_rej = o || u;
    if (clr || nsp < m_wm) m_wm = nsp;
    m_sp = nsp;
  endtask

  task automatic check_model(input string tag);
    expect_eq({tag, ".sp"},    int'(sp_addr),      m_sp);
    expect_eq({tag, ".fp"},    int'(fp_addr),      m_fp);
    expect_eq({tag, ".depth"}, int'(sp_depth),     TOP - m_sp);
    expect_eq({tag, ".wm"},    int'(sp_watermark), m_wm);
    expect_eq({tag, ".ovf"},   int'(overflow),     int'(m_ovf));
    expect_eq({tag, ".unf"},   int'(underflow),    int'(m_unf));
    expect_eq({tag, ".rej"},   int'(op_rejected),  int'(m_rej));
  endtask

  task automatic step(input string tag, input int op, input int amt, input int val, input bit clr);
    sp_op = 3'(op); sp_amount = SW'(amt); sp_load_value = AW'(val); fault_clear = clr;
    @(posedge clk);
    model_op(op, amt, val, clr);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    sp_op = 3'd0; fault_clear = 1'b0;
    #2 rst_async = 1'b1;
    @(posedge clk);
    #2 rst_async = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    do_reset();
    #1 check_model("reset");

    // Three pushes of 2
    step("p1a", 1, 2, 0, 0); expect_eq("p1a.const", int'(sp_addr), 'h3FFD);
    step("p1b", 1, 2, 0, 0); expect_eq("p1b.const", int'(sp_addr), 'h3FFB);
    step("p1c", 1, 2, 0, 0); expect_eq("p1c.const", int'(sp_addr), 'h3FF9);
    expect_eq("p1.depth", int'(sp_depth), 6);
    expect_eq("p1.wm", int'(sp_watermark), 'h3FF9);

    // Underflow from reset, one-cycle reject pulse, sticky flag
    do_reset();
    step("p2pop", 2, 1, 0, 0);
    expect_eq("p2.unf", int'(underflow), 1);
    expect_eq("p2.rej", int'(op_rejected), 1);
    step("p2push", 1, 1, 0, 0);
    expect_eq("p2.sp", int'(sp_addr), 'h3FFE);
    expect_eq("p2.rej_drop", int'(op_rejected), 0);
    expect_eq("p2.unf_sticky", int'(underflow), 1);
    step("p2zero_push", 1, 0, 0, 0);
    step("p2zero_pop", 2, 0, 0, 0);

    // Lower bound: exact limit accepted, one past rejected
    do_reset();
    step("p3load", 3, 0, 'h3F03, 0);
    step("p3push3", 1, 3, 0, 0); expect_eq("p3.at_limit", int'(sp_addr), 'h3F00);
    step("p3push1", 1, 1, 0, 0); expect_eq("p3.ovf", int'(overflow), 1);
    step("p3loadlo", 3, 0, 'h3EFF, 0); expect_eq("p3.sp_kept", int'(sp_addr), 'h3F00);
    expect_eq("p3.rej_held", int'(op_rejected), 1);
    step("p3reserved", 6, 7, 0, 0); expect_eq("p3.resv_rej", int'(op_rejected), 0);

    // Fault clear races a new overflow, then a plain clear
    step("p5clr_ovf", 1, 5, 0, 1); expect_eq("p5.ovf_wins", int'(overflow), 1);
    step("p5clr", 0, 0, 0, 1);
    expect_eq("p5.ovf_clr", int'(overflow), 0);
    expect_eq("p5.wm", int'(sp_watermark), 'h3F00);

    // Frame pointer save/restore
    do_reset();
    step("p4push4", 1, 4, 0, 0);
    step("p4setfp", 4, 0, 0, 0);
    step("p4push7", 1, 7, 0, 0); expect_eq("p4.sp", int'(sp_addr), 'h3FF4);
    step("p4restore", 5, 0, 0, 0);
    expect_eq("p4.sp_rest", int'(sp_addr), 'h3FFB);
    expect_eq("p4.fp", int'(fp_addr), 'h3FFB);
    expect_eq("p4.wm", int'(sp_watermark), 'h3FF4);
    step("p4loadhi", 3, 0, 'h0, 0);

    // Async reset mid-cycle with a push presented
    step("p6load", 3, 0, 'h3F10, 0);
    sp_op = 3'd1; sp_amount = 3'd3;
    #3 rst_async = 1'b1;
    #1;
    model_reset();
    check_model("p6async");
    expect_eq("p6.sp_const", int'(sp_addr), 'h3FFF);
    @(posedge clk);
    #2 rst_async = 1'b0;
    sp_op = 3'd0;
    #1 check_model("p6held");
    step("p6nop", 0, 0, 0, 0);

    // Randomized ops against the reference model
    for (int i = 0; i < 400; i++) begin
      int op, amt, val;
      bit clr;
      op  = $urandom_range(0, 7);
      amt = $urandom_range(0, 7);
      val = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 'h3FFF))
                                        : int'($urandom_range('h3EF8, 'h3FFF));
      clr = ($urandom_range(0, 7) == 0);
      step("rand", op, amt, val, clr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
